accum_feeder: RTL and testbench

ACCUM_FEEDER -- requirements
Module: accum_feeder

---
 rtl/accum_pkg.sv | 23 ++
 rtl/strobe_timer.sv | 38 +++
 rtl/accum_feeder.sv | 134 +++++++++++++
 tb/tb_accum_feeder.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/accum_pkg.sv
// Shared types and constants for the accumulator feeder and its window timer.
package accum_pkg;

   localparam int unsigned DATA_W       = 8;
   localparam int unsigned TMR_W        = 8;
   localparam int unsigned LOW_CYC_DEF  = 2;
   localparam int unsigned HIGH_CYC_DEF = 2;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_LOAD = 3'd1,
      ST_LOW  = 3'd2,
      ST_HIGH = 3'd3,
      ST_DONE = 3'd4
   } state_e;

   // Delivery context latched on an accepted start.
   typedef struct packed {
      logic [DATA_W-1:0] rem;
      logic [DATA_W-1:0] stp;
   } feed_ctx_t;

endpackage

// File: rtl/strobe_timer.sv
// Loadable down-counter with a registered zero flag; times the x low/high windows.
module strobe_timer
   import accum_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             load_i,
   input  logic [TMR_W-1:0] load_val_i,
   input  logic             dec_i,
   output logic             zero_o
);

   logic [TMR_W-1:0] cnt_q, cnt_d;
   logic             zero_q;

   // Load has priority; decrement stops at zero.
   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = load_val_i;
      end else if (dec_i && (cnt_q != '0)) begin
         cnt_d = cnt_q - TMR_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q  <= '0;
         zero_q <= 1'b1;
      end else begin
         cnt_q  <= cnt_d;
         zero_q <= (cnt_d == '0);
      end
   end

   assign zero_o = zero_q;

endmodule

// File: rtl/accum_feeder.sv
// Splits a target total into transfers of at most step, strobing each one to an
// edge-triggered accumulator on the falling edge of x.
module accum_feeder
   import accum_pkg::*;
#(
   parameter int unsigned LOW_CYC  = LOW_CYC_DEF,
   parameter int unsigned HIGH_CYC = HIGH_CYC_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [DATA_W-1:0] target,
   input  logic [DATA_W-1:0] step,
   output logic              x,
   output logic [DATA_W-1:0] value,
   output logic              busy,
   output logic              done,
   output logic [DATA_W-1:0] count
);

   state_e            state_q, state_d;
   feed_ctx_t         ctx_q, ctx_d;
   logic [DATA_W-1:0] value_q, value_d;
   logic [DATA_W-1:0] count_q, count_d;
   logic              x_q, busy_q, done_q;

   logic              tmr_load;
   logic [TMR_W-1:0]  tmr_val;
   logic              tmr_dec;
   logic              tmr_zero;

   logic [DATA_W-1:0] xfer_amt;
   logic [DATA_W-1:0] rem_after;
   logic [DATA_W-1:0] count_inc;

   // Transfer amount never exceeds rem, so the subtraction cannot underflow.
   always_comb begin
      xfer_amt  = (ctx_q.rem < ctx_q.stp) ? ctx_q.rem : ctx_q.stp;
      rem_after = ctx_q.rem - xfer_amt;
      count_inc = (count_q == '1) ? count_q : count_q + DATA_W'(1);
   end

   strobe_timer u_timer (
      .clk        (clk),
      .rst        (rst),
      .load_i     (tmr_load),
      .load_val_i (tmr_val),
      .dec_i      (tmr_dec),
      .zero_o     (tmr_zero)
   );

   always_comb begin
      state_d  = state_q;
      ctx_d    = ctx_q;
      value_d  = value_q;
      count_d  = count_q;
      tmr_load = 1'b0;
      tmr_val  = '0;
      tmr_dec  = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (start) begin
               ctx_d.rem = target;
               ctx_d.stp = (step == '0) ? DATA_W'(1) : step;
               count_d   = '0;
               state_d   = ST_LOAD;
            end
         end
         ST_LOAD: begin
            if (ctx_q.rem == '0) begin
               state_d = ST_DONE;
            end else begin
               value_d   = xfer_amt;
               ctx_d.rem = rem_after;
               count_d   = count_inc;
               tmr_load  = 1'b1;
               tmr_val   = TMR_W'(LOW_CYC - 1);
               state_d   = ST_LOW;
            end
         end
         ST_LOW: begin
            if (tmr_zero) begin
               tmr_load = 1'b1;
               tmr_val  = TMR_W'(HIGH_CYC - 1);
               state_d  = ST_HIGH;
            end else begin
               tmr_dec = 1'b1;
            end
         end
         ST_HIGH: begin
            if (tmr_zero) begin
               state_d = ST_LOAD;
            end else begin
               tmr_dec = 1'b1;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Strobe and status outputs are registered from the next state.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         ctx_q   <= '0;
         value_q <= '0;
         count_q <= '0;
         x_q     <= 1'b1;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         ctx_q   <= ctx_d;
         value_q <= value_d;
         count_q <= count_d;
         x_q     <= (state_d != ST_LOW);
         busy_q  <= (state_d != ST_IDLE);
         done_q  <= (state_d == ST_DONE);
      end
   end

   assign x     = x_q;
   assign value = value_q;
   assign busy  = busy_q;
   assign done  = done_q;
   assign count = count_q;

endmodule

// File: tb/tb_accum_feeder.sv
// Randomized scoreboard bench for accum_feeder with a closed-loop accumulator model.
module tb_accum_feeder;

   localparam int L = 2;
   localparam int H = 2;

   typedef struct {
      int v;
      int c;
   } xfer_t;

   typedef struct {
      int cnt;
      int sum;
      int lat;
   } done_t;

   logic       clk;
   logic       rst;
   logic       start;
   logic [7:0] target;
   logic [7:0] step;
   logic       x;
   logic [7:0] value;
   logic       busy;
   logic       done;
   logic [7:0] count;

   xfer_t xq[$];
   done_t dq[$];

   int npass = 0;
   int ntot  = 0;
   int cyc   = 0;
   int start_cyc = 0;
   int tot   = 0;
   int falls = 0;
   int hold_val = 0;
   logic prev_x = 1'b1;

   accum_feeder #(.LOW_CYC(L), .HIGH_CYC(H)) dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .target (target),
      .step   (step),
      .x      (x),
      .value  (value),
      .busy   (busy),
      .done   (done),
      .count  (count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc = cyc + 1;

   task automatic chk(input string nm, input int act, input int exp);
      ntot = ntot + 1;
      if (act == exp) npass = npass + 1;
      else $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
   endtask

   // Reference: n = ceil(t/s) transfers, all full steps except the remainder last.
   task automatic model(input int t, input int s, output int n);
      int st;
      st = (s == 0) ? 1 : s;
      n  = (t + st - 1) / st;
      for (int i = 1; i <= n; i++) begin
         xfer_t e;
         e.v = (i < n) ? st : t - (n - 1) * st;
         e.c = (i > 255) ? 255 : i;
         xq.push_back(e);
      end
      begin
         done_t d;
         d.cnt = (n > 255) ? 255 : n;
         d.sum = t;
         d.lat = 1 + n * (1 + L + H) + 1;
         dq.push_back(d);
      end
   endtask

   // Monitor plays the accumulator: tot += value on each falling edge of x.
   initial begin
      forever begin
         @(negedge clk);
         if (rst) begin
            if (prev_x && !x) begin
               falls = falls + 1;
               if (xq.size() == 0) begin
                  chk("unexpected_xfer", 1, 0);
               end else begin
                  xfer_t e;
                  e = xq.pop_front();
                  chk("xfer_value", int'(value), e.v);
                  chk("xfer_count", int'(count), e.c);
               end
               tot = tot + int'(value);
               hold_val = int'(value);
            end else if (!x) begin
               chk("value_stable_low", int'(value), hold_val);
            end
            if (done) begin
               if (dq.size() == 0) begin
                  chk("unexpected_done", 1, 0);
               end else begin
                  done_t d;
                  d = dq.pop_front();
                  chk("done_count", int'(count), d.cnt);
                  chk("done_total", tot, d.sum);
                  chk("done_latency", cyc - start_cyc, d.lat);
                  chk("done_busy", int'(busy), 1);
                  chk("done_pending_xfers", xq.size(), 0);
               end
            end
         end
         prev_x = x;
      end
   end

   task automatic deliver(input int t, input int s, input bit disturb);
      int n;
      int k;
      @(posedge clk);
      #2;
      tot = 0;
      model(t, s, n);
      start     = 1'b1;
      target    = 8'(t);
      step      = 8'(s);
      start_cyc = cyc;
      @(posedge clk);
      #2;
      start  = 1'b0;
      target = 8'($urandom);
      step   = 8'($urandom);
      if (disturb && n > 0) begin
         repeat (2) @(posedge clk);
         #2;
         start  = 1'b1;
         target = 8'($urandom);
         step   = 8'($urandom);
         @(posedge clk);
         #2;
         start = 1'b0;
      end
      k = 0;
      while ((xq.size() != 0 || dq.size() != 0) && k < 2000) begin
         @(negedge clk);
         k++;
      end
      if (k >= 2000) begin
         chk("delivery_timeout", 1, 0);
         xq.delete();
         dq.delete();
      end
      @(negedge clk);
      #1;
      chk("idle_busy", int'(busy), 0);
      chk("idle_x", int'(x), 1);
      chk("idle_done", int'(done), 0);
      chk("idle_count", int'(count), (n > 255) ? 255 : n);
   endtask

   task automatic check_reset_state(input string tag);
      chk({tag, "_x"}, int'(x), 1);
      chk({tag, "_busy"}, int'(busy), 0);
      chk({tag, "_done"}, int'(done), 0);
      chk({tag, "_count"}, int'(count), 0);
      chk({tag, "_value"}, int'(value), 0);
   endtask

   initial begin
      int n;
      int k;
      rst    = 1'b1;
      start  = 1'b0;
      target = '0;
      step   = '0;
      #3 rst = 1'b0;
      #4;
      check_reset_state("reset");
      repeat (2) @(posedge clk);
      #2 rst = 1'b1;

      deliver(10, 3, 1'b1);
      deliver(0, 5, 1'b0);
      deliver(7, 0, 1'b1);
      deliver(200, 255, 1'b0);

      // Reset during the second low window of 9/4, then a fresh 5/4 delivery.
      @(posedge clk);
      #2;
      tot = 0;
      falls = 0;
      model(9, 4, n);
      start = 1'b1;
      target = 8'd9;
      step = 8'd4;
      start_cyc = cyc;
      @(posedge clk);
      #2 start = 1'b0;
      k = 0;
      while (falls < 2 && k < 200) begin
         @(negedge clk);
         k++;
      end
      if (k >= 200) chk("reset_wait_timeout", 1, 0);
      #2;
      chk("pre_reset_x_low", int'(x), 0);
      rst = 1'b0;
      #1;
      check_reset_state("midxfer_reset");
      xq.delete();
      dq.delete();
      repeat (3) @(posedge clk);
      #3 rst = 1'b1;
      repeat (4) @(negedge clk);
      #1;
      chk("post_reset_idle_busy", int'(busy), 0);
      deliver(5, 4, 1'b0);

      deliver(100, 7, 1'b1);
      deliver(255, 1, 1'b0);
      deliver(255, 255, 1'b0);
      deliver(1, 200, 1'b1);

      for (int r = 0; r < 15; r++) begin
         deliver(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                 1'($urandom_range(0, 1)));
      end

      $display("%0d/%0d checks passed", npass, ntot);
      $finish;
   end

endmodule
